// File: rtl/npu_requant_pack_if.sv
// Stream interface of npu_requant_pack.
//   in_valid/in_ready/in_data            : accumulator input stream (MAC array -> block)
//   out_valid/out_ready/out_data/out_count: packed INT8 word stream (block -> writeback)
// The block itself connects through the slave modport; the producer/consumer
// side (MAC array + writeback, or a testbench) uses the master modport.
interface npu_requant_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/npu_requant_pack.sv
// npu_requant_pack: NPU output stage.
// Takes signed 32-bit dot products, applies bias, unsigned scale, rounding
// right shift (half toward +inf), optional ReLU, zero point and INT8
// saturation, packs four bytes per 32-bit word (byte 0 = oldest) and buffers
// words in a first-word-fall-through FIFO.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : in_valid/in_ready/in_data, out_valid/out_ready/
//                        out_data/out_count
//   cfg_bias/scale/shift/zero_point/relu : per-layer quasi-static config
//   flush              : pulse, emit a partially packed word
//   busy               : any data in flight, held, pending or buffered
module npu_requant_pack #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  npu_requant_pack_if.slave bus,
  input  logic [31:0] cfg_bias,
  input  logic [15:0] cfg_scale,
  input  logic [4:0]  cfg_shift,
  input  logic [7:0]  cfg_zero_point,
  input  logic        cfg_relu,
  input  logic        flush,
  output logic        busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  // pipeline stages
  logic               r_s1_v;
  logic [32:0]        r_s1_sum;
  logic               r_s2_v;
  logic signed [49:0] r_s2_prod;
  logic               r_s3_v;
  logic [7:0]         r_s3_q;

  // packer / flush
  logic [1:0]         r_lane;
  logic [23:0]        r_hold;
  logic               r_flush_pend;

  // FIFO
  logic [31:0]        r_mem_data [FIFO_DEPTH];
  logic [2:0]         r_mem_cnt  [FIFO_DEPTH];
  logic [AW-1:0]      r_wr;
  logic [AW-1:0]      r_rd;
  logic [CW-1:0]      r_count;

  logic               w_accept;
  logic               w_pipe_empty;
  logic               w_full_push;
  logic               w_flush_push;
  logic               w_push_pending;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_stall;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_push_data;
  logic [2:0]         w_push_cnt;

  logic signed [50:0] w_prod_x;
  logic signed [50:0] w_rnd;
  logic signed [50:0] w_shr;
  logic signed [50:0] w_relu;
  logic signed [50:0] w_q;
  logic [7:0]         w_q8;

  // ---------------- control ----------------
  always_comb begin
    w_pipe_empty   = !r_s1_v && !r_s2_v && !r_s3_v;
    w_full_push    = r_s3_v && (r_lane == 2'd3);
    w_flush_push   = r_flush_pend && w_pipe_empty && (r_lane != 2'd0);
    w_push_pending = w_full_push || w_flush_push;
    w_fifo_full    = (r_count == CW'(FIFO_DEPTH));
    w_fifo_empty   = (r_count == '0);
    // stall looks only at registered FIFO occupancy, so a same-cycle pop
    // never frees the slot and in_ready has no path from out_ready
    w_stall        = w_push_pending && w_fifo_full;
    w_push         = w_push_pending && !w_fifo_full;
    w_pop          = !w_fifo_empty && bus.out_ready;
    bus.in_ready   = !w_stall && !r_flush_pend;
    w_accept       = bus.in_valid && bus.in_ready;
    busy           = r_s1_v || r_s2_v || r_s3_v || (r_lane != 2'd0) ||
                     r_flush_pend || !w_fifo_empty;
  end

  // ---------------- S3 arithmetic ----------------
  always_comb begin
    w_prod_x = 51'(r_s2_prod);
    w_rnd    = w_prod_x;
    if (cfg_shift != 5'd0) begin
      w_rnd = w_prod_x + (51'sd1 <<< (cfg_shift - 5'd1));
    end
    w_shr  = w_rnd >>> cfg_shift;
    w_relu = (cfg_relu && w_shr[50]) ? '0 : w_shr;
    w_q    = w_relu + 51'($signed(cfg_zero_point));
    if (w_q > 51'sd127) begin
      w_q8 = 8'h7F;
    end else if (w_q < -51'sd128) begin
      w_q8 = 8'h80;
    end else begin
      w_q8 = w_q[7:0];
    end
  end

  // ---------------- pipeline ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_sum  <= '0;
      r_s2_v    <= 1'b0;
      r_s2_prod <= '0;
      r_s3_v    <= 1'b0;
      r_s3_q    <= '0;
    end else if (!w_stall) begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_sum <= {bus.in_data[31], bus.in_data} + {cfg_bias[31], cfg_bias};
      end
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_prod <= 50'($signed(r_s1_sum)) * 50'($signed({1'b0, cfg_scale}));
      end
      r_s3_v <= r_s2_v;
      if (r_s2_v) begin
        r_s3_q <= w_q8;
      end
    end
  end

  // ---------------- packer ----------------
  always_comb begin
    if (w_full_push) begin
      w_push_data = {r_s3_q, r_hold};
      w_push_cnt  = 3'd4;
    end else begin
      // stale bytes above the current lane are left over from the previous
      // word, so mask them out of a partial word
      case (r_lane)
        2'd1:    w_push_data = {24'h0, r_hold[7:0]};
        2'd2:    w_push_data = {16'h0, r_hold[15:0]};
        default: w_push_data = {8'h0, r_hold};
      endcase
      w_push_cnt = {1'b0, r_lane};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane       <= '0;
      r_hold       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (!w_stall) begin
        if (r_s3_v) begin
          if (r_lane == 2'd3) begin
            r_lane <= '0;
          end else begin
            case (r_lane)
              2'd0:    r_hold[7:0]   <= r_s3_q;
              2'd1:    r_hold[15:8]  <= r_s3_q;
              default: r_hold[23:16] <= r_s3_q;
            endcase
            r_lane <= r_lane + 2'd1;
          end
        end else if (w_flush_push) begin
          r_lane <= '0;
        end
      end
      // with the pipeline empty the only possible stall is a blocked flush
      // push, so !w_stall means the flush either pushed or had nothing to do
      if (r_flush_pend) begin
        if (w_pipe_empty && !w_stall) begin
          r_flush_pend <= 1'b0;
        end
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr] <= w_push_data;
      r_mem_cnt[r_wr]  <= w_push_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    bus.out_valid = !w_fifo_empty;
    bus.out_data  = w_fifo_empty ? '0 : r_mem_data[r_rd];
    bus.out_count = w_fifo_empty ? '0 : r_mem_cnt[r_rd];
  end

endmodule

// File: tb/tb_npu_requant_pack.sv
module tb_npu_requant_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cfg_bias;
  logic [15:0] cfg_scale;
  logic [4:0]  cfg_shift;
  logic [7:0]  cfg_zero_point;
  logic        cfg_relu;
  logic        flush;
  logic        busy;

  npu_requant_pack_if bus ();

  npu_requant_pack #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .cfg_bias       (cfg_bias),
    .cfg_scale      (cfg_scale),
    .cfg_shift      (cfg_shift),
    .cfg_zero_point (cfg_zero_point),
    .cfg_relu       (cfg_relu),
    .flush          (flush),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] acc;
    logic [31:0] bias;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic [7:0]  zp;
    logic        relu;
    logic [7:0]  eb;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  c;
  } word_t;

  vec_t        vecs [16];
  word_t       exp_q [$];
  word_t       mon_w;
  int          checks = 0;
  int          errors = 0;
  int          exp_lane = 0;
  logic [31:0] exp_word = '0;

  // Reference requantisation of one accumulator under the current config.
  function automatic logic [7:0] model(input logic [31:0] acc);
    longint a, b, sc, zz, r;
    int     sh;
    a  = $signed(acc);
    b  = $signed(cfg_bias);
    sc = cfg_scale;
    zz = $signed(cfg_zero_point);
    sh = cfg_shift;
    r  = (a + b) * sc;
    if (sh > 0) r = (r + (longint'(1) <<< (sh - 1))) >>> sh;
    if (cfg_relu && r < 0) r = 0;
    r = r + zz;
    if (r > 127) return 8'h7F;
    if (r < -128) return 8'h80;
    return r[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic accept_byte(input logic [7:0] b);
    exp_word[8*exp_lane +: 8] = b;
    exp_lane++;
    if (exp_lane == 4) begin
      exp_q.push_back('{exp_word, 3'd4});
      exp_lane = 0;
      exp_word = '0;
    end
  endtask

  task automatic model_flush();
    if (exp_lane > 0) exp_q.push_back('{exp_word, 3'(exp_lane)});
    exp_lane = 0;
    exp_word = '0;
  endtask

  // Called and returns at posedge+1.
  task automatic send(input logic [31:0] d, input logic [7:0] eb);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        accept_byte(eb);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    model_flush();
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: busy %b, %0d words outstanding, required 0/0", busy, exp_q.size());
    end
  endtask

  task automatic set_identity();
    cfg_bias = '0; cfg_scale = 16'd1; cfg_shift = '0; cfg_zero_point = '0; cfg_relu = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"},  bus.out_data,       32'd0);
    chk({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
    chk({tag, "_busy"},      32'(busy),          32'd0);
  endtask

  // Scoreboard: a word transfers at the posedge following this negedge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h count %0d, expected no word", bus.out_data, bus.out_count);
      end else begin
        mon_w = exp_q.pop_front();
        if (bus.out_data !== mon_w.d || bus.out_count !== mon_w.c) begin
          errors++;
          $display("FAIL out_word: got %h count %0d, expected %h count %0d",
                   bus.out_data, bus.out_count, mon_w.d, mon_w.c);
        end
      end
    end
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    //          acc           bias          scale     shift  zp     relu  expected
    vecs[0]  = '{32'd100,      32'd0,        16'd3,    5'd2,  8'hFB, 1'b0, 8'h46};
    vecs[1]  = '{32'hFFFFFFFA, 32'd0,        16'd1,    5'd2,  8'h00, 1'b0, 8'hFF};
    vecs[2]  = '{32'd1000,     32'd24,       16'd1,    5'd3,  8'h00, 1'b0, 8'h7F};
    vecs[3]  = '{32'hFFFFEC78, 32'd24,       16'd1,    5'd3,  8'h00, 1'b0, 8'h80};
    vecs[4]  = '{32'hFFFFFFFA, 32'd0,        16'd1,    5'd0,  8'h03, 1'b1, 8'h03};
    vecs[5]  = '{32'd5,        32'd0,        16'd1,    5'd1,  8'h00, 1'b0, 8'h03};
    vecs[6]  = '{32'hFFFFFFFB, 32'd0,        16'd1,    5'd1,  8'h00, 1'b0, 8'hFE};
    vecs[7]  = '{32'd50,       32'd0,        16'd1,    5'd0,  8'h9C, 1'b1, 8'hCE};
    vecs[8]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 16'hFFFF, 5'd31, 8'h00, 1'b0, 8'h7F};
    vecs[9]  = '{32'h80000000, 32'h80000000, 16'd1,    5'd26, 8'h00, 1'b0, 8'hC0};
    vecs[10] = '{32'h40000000, 32'd0,        16'd2,    5'd31, 8'h00, 1'b0, 8'h01};
    vecs[11] = '{32'd0,        32'd0,        16'd1,    5'd0,  8'h80, 1'b0, 8'h80};
    vecs[12] = '{32'd10,       32'd0,        16'd1,    5'd0,  8'h7F, 1'b0, 8'h7F};
    vecs[13] = '{32'hFFFFFFFD, 32'd0,        16'd1,    5'd1,  8'h00, 1'b0, 8'hFF};
    vecs[14] = '{32'h01000000, 32'd0,        16'd0,    5'd0,  8'h00, 1'b0, 8'h00};
    vecs[15] = '{32'hFFFFFC18, 32'd0,        16'd1,    5'd0,  8'h80, 1'b1, 8'h80};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    flush = 1'b0;
    set_identity();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic packing and latency of the 4th byte
    send(32'd1, 8'h01);
    send(32'd2, 8'h02);
    send(32'd3, 8'h03);
    send(32'd4, 8'h04);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("latency_early_out_valid", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
    chk("basic_out_data", bus.out_data, 32'h04030201);
    @(posedge clk);
    #1;
    wait_idle();

    // requantisation table, each result flushed as a 1-byte word
    for (int i = 0; i < 16; i++) begin
      cfg_bias = vecs[i].bias; cfg_scale = vecs[i].scale; cfg_shift = vecs[i].shift;
      cfg_zero_point = vecs[i].zp; cfg_relu = vecs[i].relu;
      send(vecs[i].acc, vecs[i].eb);
      pulse_flush();
      wait_idle();
    end
    set_identity();

    // partial flush: expect 0x00000201 count 2
    send(32'd1, model(32'd1));
    send(32'd2, model(32'd2));
    pulse_flush();
    wait_idle();

    // flush with nothing held pushes no word
    pulse_flush();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("empty_flush_no_word", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    wait_idle();

    // flush while S1..S3 are full: held off until drained, in_ready low
    send(32'd10, model(32'd10));
    send(32'd11, model(32'd11));
    send(32'd12, model(32'd12));
    pulse_flush();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_drain_in_ready", 32'(bus.in_ready), 32'd0);
      chk("flush_drain_out_valid", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    chk("flush_done_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_done_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    wait_idle();

    // backpressure: 20 inputs with the consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(32'(i * 13 - 120), model(32'(i * 13 - 120)));
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_head_word", bus.out_data, exp_q[0].d);
    chk("bp_words_outstanding", 32'(exp_q.size()), 32'd5);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_idle();

    // reset mid-stream
    send(32'd7, model(32'd7));
    send(32'd8, model(32'd8));
    rst_n = 1'b0;
    exp_q.delete();
    exp_lane = 0;
    exp_word = '0;
    #1;
    chk_reset_vals("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h21, model(32'h21));
    send(32'h22, model(32'h22));
    send(32'h23, model(32'h23));
    send(32'h24, model(32'h24));
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
